// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute sequencer with an 8-bit accumulator datapath,
// acting as the master of a 16x8 RAM that has combinational reads and
// level-sensitive writes.
//
// Instruction word: IR[7:4] is the opcode; IR[3:0] is a RAM address or an immediate.
//
// Ports:
//   CLK           clock; all state changes on the rising edge
//   RST           synchronous, active-high reset
//   RUN           start request, sampled only while idle
//   RAM_ADDRESS   RAM address (registered)
//   RAM_DATA_IN   RAM write data (registered)
//   RAM_OPCODE    RAM command, 0 = read, 1 = write (registered)
//   RAM_DATA_OUT  RAM read data (combinational from the RAM)
//   OUT_DATA      output register, loaded by OUT
//   OUT_VALID     one-cycle strobe after OUT executes
//   HALTED        high while halted
//   FLAG_C        carry flag (ADD carry-out, SUB no-borrow)
//   FLAG_Z        zero flag
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for RUN; RAM_ADDRESS shows PC
// ST_FETCH | RAM_ADDRESS = PC; the IR is loaded and PC advances
// ST_EXEC  | RAM_ADDRESS = IR[3:0]; executes the instruction in IR
// ST_HALT  | parked after HLT until reset
module cpu_sequencer #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  output logic [3:0] RAM_ADDRESS,
  output logic [7:0] RAM_DATA_IN,
  output logic       RAM_OPCODE,
  input  logic [7:0] RAM_DATA_OUT,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  output logic       HALTED,
  output logic       FLAG_C,
  output logic       FLAG_Z
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state, state_n;
  logic [3:0] pc, pc_n;
  logic [7:0] ir, ir_n;
  logic [7:0] acc, acc_n;
  logic       flag_c, flag_c_n;
  logic       flag_z, flag_z_n;
  logic [7:0] out_data, out_data_n;
  logic       out_valid, out_valid_n;
  logic       halted, halted_n;
  logic [3:0] ram_addr, ram_addr_n;
  logic [7:0] ram_din, ram_din_n;
  logic       ram_op, ram_op_n;
  logic [8:0] sum9;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      ir        <= 8'h00;
      acc       <= 8'h00;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      ram_addr  <= RESET_PC;
      ram_din   <= 8'h00;
      ram_op    <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      ir        <= ir_n;
      acc       <= acc_n;
      flag_c    <= flag_c_n;
      flag_z    <= flag_z_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      halted    <= halted_n;
      ram_addr  <= ram_addr_n;
      ram_din   <= ram_din_n;
      ram_op    <= ram_op_n;
    end
  end

  // The RAM-side signals are computed for the state being entered. They are
  // registered, so they stay stable for the whole cycle, including the STA
  // write cycle.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ir_n        = ir;
    acc_n       = acc;
    flag_c_n    = flag_c;
    flag_z_n    = flag_z;
    out_data_n  = out_data;
    out_valid_n = 1'b0;
    halted_n    = halted;
    ram_addr_n  = pc;
    ram_din_n   = ram_din;
    ram_op_n    = 1'b0;
    sum9        = 9'h000;

    case (state)
      ST_IDLE: begin
        if (RUN) state_n = ST_FETCH;
      end

      ST_FETCH: begin
        ir_n       = RAM_DATA_OUT;
        pc_n       = pc + 4'd1;
        state_n    = ST_EXEC;
        ram_addr_n = RAM_DATA_OUT[3:0];
        // A store is decoded one edge early, so the write strobe comes
        // straight from a flop during EXEC.
        if (RAM_DATA_OUT[7:4] == OP_STA) begin
          ram_op_n  = 1'b1;
          ram_din_n = acc;
        end
      end

      ST_EXEC: begin
        state_n = ST_FETCH;
        case (ir[7:4])
          OP_LDA: acc_n = RAM_DATA_OUT;
          OP_ADD: begin
            sum9     = {1'b0, acc} + {1'b0, RAM_DATA_OUT};
            acc_n    = sum9[7:0];
            flag_c_n = sum9[8];
            flag_z_n = (sum9[7:0] == 8'h00);
          end
          OP_SUB: begin
            sum9     = {1'b0, acc} + {1'b0, ~RAM_DATA_OUT} + 9'd1;
            acc_n    = sum9[7:0];
            flag_c_n = sum9[8];
            flag_z_n = (sum9[7:0] == 8'h00);
          end
          OP_LDI: acc_n = {4'h0, ir[3:0]};
          OP_JMP: pc_n = ir[3:0];
          OP_JC:  if (flag_c) pc_n = ir[3:0];
          OP_JZ:  if (flag_z) pc_n = ir[3:0];
          OP_OUT: begin
            out_data_n  = acc;
            out_valid_n = 1'b1;
          end
          OP_HLT: begin
            state_n  = ST_HALT;
            halted_n = 1'b1;
          end
          default: ;
        endcase
        // The next FETCH uses the updated PC, so a taken jump has no delay slot.
        ram_addr_n = pc_n;
      end

      ST_HALT: begin
        state_n = ST_HALT;
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign RAM_ADDRESS = ram_addr;
  assign RAM_DATA_IN = ram_din;
  assign RAM_OPCODE  = ram_op;
  assign OUT_DATA    = out_data;
  assign OUT_VALID   = out_valid;
  assign HALTED      = halted;
  assign FLAG_C      = flag_c;
  assign FLAG_Z      = flag_z;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer. It holds a RAM model and an instruction-level
// reference interpreter. The interpreter queues the expected fetch
// addresses, RAM writes and OUT strobes, each tagged with its cycle number.
// A negedge monitor pops these entries and compares them with the DUT.
module tb_cpu_sequencer;
  localparam logic [3:0] RESET_PC = 4'h0;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RUN = 1'b0;
  logic [3:0] RAM_ADDRESS;
  logic [7:0] RAM_DATA_IN;
  logic       RAM_OPCODE;
  logic [7:0] RAM_DATA_OUT;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       HALTED;
  logic       FLAG_C;
  logic       FLAG_Z;

  cpu_sequencer #(.RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN),
    .RAM_ADDRESS(RAM_ADDRESS), .RAM_DATA_IN(RAM_DATA_IN),
    .RAM_OPCODE(RAM_OPCODE), .RAM_DATA_OUT(RAM_DATA_OUT),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .HALTED(HALTED),
    .FLAG_C(FLAG_C), .FLAG_Z(FLAG_Z)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [16];
  logic [7:0] prog [16];
  logic [7:0] mm [16];

  assign RAM_DATA_OUT = mem[RAM_ADDRESS];
  always @(posedge CLK) if (RAM_OPCODE) mem[RAM_ADDRESS] <= RAM_DATA_IN;

  int edges = 0;
  always @(posedge CLK) edges <= edges + 1;

  typedef struct { int cyc; int addr; int val; } ev_t;
  ev_t fq[$];
  ev_t wq[$];
  ev_t oq[$];

  int  base = 0;
  bit  sb_en = 1'b0;
  int  tests = 0;
  int  fails = 0;
  int  halt_seen = 0;
  bit  m_c, m_z, m_halted;
  int  m_halt_cyc;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Instruction-level reference: a plain ISA interpreter over its own memory copy.
  task automatic model_run(input int n);
    logic [3:0] pc, opd;
    logic [7:0] a, ir, m;
    int s;
    pc = RESET_PC; a = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_halted = 1'b0; m_halt_cyc = 0;
    for (int k = 0; k < n; k++) begin
      fq.push_back('{cyc: 2*k+1, addr: int'(pc), val: 0});
      ir  = mm[pc];
      pc  = pc + 4'd1;
      opd = ir[3:0];
      m   = mm[opd];
      case (ir[7:4])
        4'h1: a = m;
        4'h2: begin s = int'(a) + int'(m); m_c = (s > 255); a = 8'(s); m_z = (a == 8'h00); end
        4'h3: begin m_c = (a >= m); a = a - m; m_z = (a == 8'h00); end
        4'h4: begin mm[opd] = a; wq.push_back('{cyc: 2*k+2, addr: int'(opd), val: int'(a)}); end
        4'h5: a = {4'h0, opd};
        4'h6: pc = opd;
        4'h7: if (m_c) pc = opd;
        4'h8: if (m_z) pc = opd;
        4'hE: oq.push_back('{cyc: 2*k+3, addr: 0, val: int'(a)});
        4'hF: begin m_halted = 1'b1; m_halt_cyc = 2*k+3; break; end
        default: ;
      endcase
    end
  endtask

  always @(negedge CLK) begin
    int cyc;
    if (sb_en) begin
      cyc = edges - base;
      if (fq.size() > 0 && fq[0].cyc == cyc) begin
        chk("fetch_addr", int'(RAM_ADDRESS), fq[0].addr);
        void'(fq.pop_front());
      end
      if (RAM_OPCODE) begin
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
          chk("write_addr", int'(RAM_ADDRESS), wq[0].addr);
          chk("write_data", int'(RAM_DATA_IN), wq[0].val);
          void'(wq.pop_front());
        end else chk("write_strobe", int'(RAM_OPCODE), 0);
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        chk("write_strobe", int'(RAM_OPCODE), 1);
        void'(wq.pop_front());
      end
      if (OUT_VALID) begin
        if (oq.size() > 0 && oq[0].cyc == cyc) begin
          chk("out_data", int'(OUT_DATA), oq[0].val);
          void'(oq.pop_front());
        end else chk("out_valid", int'(OUT_VALID), 0);
      end else if (oq.size() > 0 && oq[0].cyc <= cyc) begin
        chk("out_valid", int'(OUT_VALID), 1);
        void'(oq.pop_front());
      end
      if (HALTED && halt_seen == 0) halt_seen = cyc;
    end
  end

  task automatic do_reset();
    RST = 1'b1; RUN = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_cycle(input int n);
    while (edges - base < n) @(negedge CLK);
  endtask

  task automatic load_and_start(input int k_instr);
    do_reset();
    for (int i = 0; i < 16; i++) begin mem[i] = prog[i]; mm[i] = prog[i]; end
    fq.delete(); wq.delete(); oq.delete();
    model_run(k_instr);
    @(negedge CLK);
    RUN = 1'b1; base = edges; halt_seen = 0; sb_en = 1'b1;
    @(negedge CLK);
    RUN = 1'b0;
  endtask

  task automatic run_prog(input int k_instr);
    load_and_start(k_instr);
    wait_cycle(2*k_instr + 1);
    #1;
    for (int i = 0; i < 16; i++) chk("ram_contents", int'(mem[i]), int'(mm[i]));
    chk("flag_c", int'(FLAG_C), int'(m_c));
    chk("flag_z", int'(FLAG_Z), int'(m_z));
    chk("halted", int'(HALTED), int'(m_halted));
    if (m_halted) chk("halt_cycle", halt_seen, m_halt_cyc);
    chk("pending_fetch", fq.size(), 0);
    chk("pending_write", wq.size(), 0);
    chk("pending_out", oq.size(), 0);
    sb_en = 1'b0;
    RST = 1'b1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  initial begin
    int k;
    logic [3:0] op;

    // Reset values, then idle with RUN low and a store-bearing program in RAM.
    for (int i = 0; i < 16; i++) mem[i] = 8'h4F;
    repeat (2) @(negedge CLK);
    chk("rst_ram_opcode", int'(RAM_OPCODE), 0);
    chk("rst_ram_address", int'(RAM_ADDRESS), int'(RESET_PC));
    chk("rst_ram_data_in", int'(RAM_DATA_IN), 0);
    chk("rst_out_data", int'(OUT_DATA), 0);
    chk("rst_out_valid", int'(OUT_VALID), 0);
    chk("rst_halted", int'(HALTED), 0);
    chk("rst_flag_c", int'(FLAG_C), 0);
    chk("rst_flag_z", int'(FLAG_Z), 0);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("idle_address", int'(RAM_ADDRESS), int'(RESET_PC));
      chk("idle_opcode", int'(RAM_OPCODE), 0);
    end

    // Add and output.
    clear_prog();
    prog[0] = 8'h55; prog[1] = 8'h2E; prog[2] = 8'hE0; prog[3] = 8'hF0; prog[14] = 8'h03;
    run_prog(4);
    chk("add_out_data", int'(OUT_DATA), 8'h08);
    chk("add_halt_cycle", halt_seen, 9);

    // Store.
    clear_prog();
    prog[0] = 8'h59; prog[1] = 8'h4F; prog[2] = 8'hF0;
    run_prog(3);
    chk("store_ram_f", int'(mem[15]), 8'h09);

    // Carry, zero and a taken JC.
    clear_prog();
    prog[0] = 8'h1E; prog[1] = 8'h2D; prog[2] = 8'h7A; prog[10] = 8'hF0;
    prog[13] = 8'h01; prog[14] = 8'hFF;
    run_prog(4);
    chk("carry_c", int'(FLAG_C), 1);
    chk("carry_z", int'(FLAG_Z), 1);

    // Subtract to zero, subtract with borrow, JZ not taken.
    clear_prog();
    prog[0] = 8'h53; prog[1] = 8'h3D; prog[2] = 8'hE0; prog[3] = 8'h53;
    prog[4] = 8'h3C; prog[5] = 8'h89; prog[6] = 8'hE0; prog[7] = 8'hF0;
    prog[9] = 8'hF0; prog[12] = 8'h04; prog[13] = 8'h03;
    run_prog(8);
    chk("sub_out_data", int'(OUT_DATA), 8'hFF);

    // All-NOP program wraps PC.
    clear_prog();
    run_prog(20);

    // Reset during the STA EXEC cycle.
    clear_prog();
    prog[0] = 8'h59; prog[1] = 8'h4F; prog[2] = 8'hF0;
    load_and_start(2);
    wait_cycle(4);
    RST = 1'b1;
    @(negedge CLK);
    sb_en = 1'b0;
    chk("midsta_opcode", int'(RAM_OPCODE), 0);
    chk("midsta_address", int'(RAM_ADDRESS), int'(RESET_PC));
    chk("midsta_data_in", int'(RAM_DATA_IN), 0);
    chk("midsta_halted", int'(HALTED), 0);
    chk("midsta_pending_write", wq.size(), 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("midsta_idle_addr", int'(RAM_ADDRESS), int'(RESET_PC));
      chk("midsta_idle_op", int'(RAM_OPCODE), 0);
    end

    // Randomized programs against the reference interpreter.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 16; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hE;
        prog[i] = {op, 4'($urandom_range(0, 15))};
      end
      k = $urandom_range(10, 40);
      run_prog(k);
    end

    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
